// File: rtl/top_field_writer_if.sv
// Field-writer bus: walker-side request/status signals plus the byte-lane DRAM write port.
// slave is the writer's view, master is the view of whatever drives it (walker + DRAM model).
interface top_field_writer_if #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 64,
    parameter int FNUM_W = 29
);
    logic                          en;
    logic [FNUM_W-1:0]             field_num;
    logic [4:0]                    field_type;
    logic [63:0]                   value;
    logic [ADDR_W-1:0]             dst_addr;
    logic [LANES-1:0]              dram_en;
    logic [LANES-1:0][ADDR_W-1:0]  dram_addr;
    logic [LANES-1:0][7:0]         dram_data;
    logic                          dram_rdwr;
    logic                          dram_ready;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [3:0]                    bytes_written;

    modport slave (
        input  en, field_num, field_type, value, dst_addr, dram_ready,
        output dram_en, dram_addr, dram_data, dram_rdwr, busy, done, error, bytes_written
    );

    modport master (
        output en, field_num, field_type, value, dst_addr, dram_ready,
        input  dram_en, dram_addr, dram_data, dram_rdwr, busy, done, error, bytes_written
    );
endinterface

// File: rtl/top_field_writer.sv
// Serialises one protobuf field (tag varint + payload, up to 15 B) into LANES-wide DRAM beats.
// Latency en->done = 2 + beats; a beat is held stable until dram_ready, new en only taken in IDLE.
module top_field_writer #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 64,
    parameter int FNUM_W = 29
) (
    input  logic              clk,
    input  logic              reset,
    top_field_writer_if.slave bus
);
    localparam int BUF_B = 15;

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_DONE} state_t;

    state_t                        r_state;
    logic [FNUM_W-1:0]             r_num;
    logic [4:0]                    r_type;
    logic [63:0]                   r_val;
    logic [ADDR_W-1:0]             r_dst;
    logic [BUF_B-1:0][7:0]         r_buf;
    logic [3:0]                    r_len;
    logic [3:0]                    r_beat;
    logic [LANES-1:0]              r_dram_en;
    logic [LANES-1:0][ADDR_W-1:0]  r_dram_addr;
    logic [LANES-1:0][7:0]         r_dram_data;
    logic                          r_rdwr;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_error;
    logic [3:0]                    r_bw;

    logic                          w_err;
    logic                          w_fixed;
    logic [2:0]                    w_wt;
    logic [3:0]                    w_fix_len;
    logic [63:0]                   w_pay;
    logic [63:0]                   w_tag;
    logic [3:0]                    w_tag_len;
    logic [3:0]                    w_pay_len;
    logic [79:0]                   w_pay_v;
    logic [3:0]                    w_len;
    logic [BUF_B-1:0][7:0]         w_rec;
    logic [BUF_B-1:0][7:0]         w_src;
    logic [3:0]                    w_src_len;
    logic [7:0]                    w_base;
    logic                          w_last;
    logic [LANES-1:0]              w_beat_en;
    logic [LANES-1:0][ADDR_W-1:0]  w_beat_addr;
    logic [LANES-1:0][7:0]         w_beat_data;

    function automatic logic [3:0] varint_len(input logic [63:0] v);
        logic [3:0] n;
        n = 4'd1;
        for (int g = 1; g < 10; g++) begin
            if ((v >> (7 * g)) != 64'd0) n = 4'(g + 1);
        end
        return n;
    endfunction

    // Groups past the encoded length come out as zero bytes, so records can be OR-merged.
    function automatic logic [9:0][7:0] varint_bytes(input logic [63:0] v);
        logic [9:0][7:0] b;
        logic [3:0]      n;
        n = varint_len(v);
        for (int g = 0; g < 10; g++) begin
            b[g] = {(4'(g + 1) < n), 7'(v >> (7 * g))};
        end
        return b;
    endfunction

    always_comb begin
        w_err     = 1'b0;
        w_fixed   = 1'b0;
        w_wt      = 3'd0;
        w_fix_len = 4'd0;
        w_pay     = r_val;
        case (r_type)
            5'd3, 5'd4:   w_pay = r_val;
            5'd5, 5'd14:  w_pay = {{32{r_val[31]}}, r_val[31:0]};
            5'd13:        w_pay = {32'd0, r_val[31:0]};
            5'd8:         w_pay = {63'd0, (r_val != 64'd0)};
            5'd17:        w_pay = {32'd0, (r_val[31:0] << 1) ^ {32{r_val[31]}}};
            5'd18:        w_pay = (r_val << 1) ^ {64{r_val[63]}};
            5'd1, 5'd6, 5'd16: begin
                w_fixed = 1'b1; w_wt = 3'd1; w_fix_len = 4'd8;
            end
            5'd2, 5'd7, 5'd15: begin
                w_fixed = 1'b1; w_wt = 3'd5; w_fix_len = 4'd4;
                w_pay = {32'd0, r_val[31:0]};
            end
            default:      w_err = 1'b1;
        endcase
        if (r_num == '0) w_err = 1'b1;

        w_tag     = 64'({r_num, w_wt});
        w_tag_len = varint_len(w_tag);
        w_pay_len = w_fixed ? w_fix_len : varint_len(w_pay);
        w_pay_v   = w_fixed ? {16'd0, w_pay} : varint_bytes(w_pay);
        w_len     = w_tag_len + w_pay_len;
        w_rec     = 120'(varint_bytes(w_tag)) | (120'(w_pay_v) << (8 * w_tag_len));
    end

    // In ENC the first beat is cut straight from the fresh record; in WR the next beat from r_buf.
    always_comb begin
        w_src     = (r_state == S_ENC) ? w_rec : r_buf;
        w_src_len = (r_state == S_ENC) ? w_len : r_len;
        w_base    = (r_state == S_ENC) ? 8'd0 : 8'(r_beat + 4'd1) * 8'(LANES);
        w_last    = (w_base >= {4'd0, r_len});
        for (int i = 0; i < LANES; i++) begin
            w_beat_en[i]   = 1'b0;
            w_beat_addr[i] = '0;
            w_beat_data[i] = 8'd0;
            if ((w_base + 8'(i)) < {4'd0, w_src_len}) begin
                w_beat_en[i]   = 1'b1;
                w_beat_addr[i] = r_dst + ADDR_W'(w_base + 8'(i));
                w_beat_data[i] = w_src[4'(w_base + 8'(i))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_type      <= '0;
            r_val       <= '0;
            r_dst       <= '0;
            r_buf       <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_dram_en   <= '0;
            r_dram_addr <= '0;
            r_dram_data <= '0;
            r_rdwr      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_bw        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_num   <= bus.field_num;
                        r_type  <= bus.field_type;
                        r_val   <= bus.value;
                        r_dst   <= bus.dst_addr;
                        r_busy  <= 1'b1;
                        r_bw    <= '0;
                        r_state <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (w_err) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_buf       <= w_rec;
                        r_len       <= w_len;
                        r_beat      <= '0;
                        r_dram_en   <= w_beat_en;
                        r_dram_addr <= w_beat_addr;
                        r_dram_data <= w_beat_data;
                        r_rdwr      <= 1'b1;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (bus.dram_ready) begin
                        if (w_last) begin
                            r_dram_en   <= '0;
                            r_dram_addr <= '0;
                            r_dram_data <= '0;
                            r_rdwr      <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_bw        <= r_len;
                            r_state     <= S_DONE;
                        end else begin
                            r_beat      <= r_beat + 4'd1;
                            r_dram_en   <= w_beat_en;
                            r_dram_addr <= w_beat_addr;
                            r_dram_data <= w_beat_data;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dram_en       = r_dram_en;
    assign bus.dram_addr     = r_dram_addr;
    assign bus.dram_data     = r_dram_data;
    assign bus.dram_rdwr     = r_rdwr;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.bytes_written = r_bw;
endmodule

// File: tb/tb_top_field_writer.sv
// Bench for top_field_writer: LANES=8 and LANES=1 instances against a byte-queue protobuf model,
// with directed vectors, random fields, random DRAM stalls and mid-write reset.
module tb_top_field_writer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    top_field_writer_if #(.LANES(8), .ADDR_W(64), .FNUM_W(29)) f8();
    top_field_writer_if #(.LANES(1), .ADDR_W(64), .FNUM_W(29)) f1();

    top_field_writer #(.LANES(8), .ADDR_W(64), .FNUM_W(29)) dut8 (.clk(clk), .reset(reset), .bus(f8.slave));
    top_field_writer #(.LANES(1), .ADDR_W(64), .FNUM_W(29)) dut1 (.clk(clk), .reset(reset), .bus(f1.slave));

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    bit         exp_err;
    logic [3:0] obs_bw;

    task automatic push_varint(input logic [63:0] v_in);
        logic [63:0] v;
        logic [6:0]  b;
        v = v_in;
        do begin
            b = v[6:0];
            v = v >> 7;
            exp_q.push_back((v != 0) ? {1'b1, b} : {1'b0, b});
        end while (v != 0);
    endtask

    task automatic model(input logic [28:0] num, input logic [4:0] ty, input logic [63:0] val);
        logic [63:0] p;
        int          wt, nfix, si;
        longint      ln;
        bit          is_var;
        exp_q.delete();
        exp_err = 0; is_var = 1; wt = 0; nfix = 0; p = val;
        case (ty)
            3, 4:  p = val;
            5, 14: begin si = val[31:0]; ln = si; p = ln; end
            13:    p = {32'd0, val[31:0]};
            8:     p = (val != 0) ? 64'd1 : 64'd0;
            17:    begin si = val[31:0]; ln = si; ln = (ln >= 0) ? 2 * ln : -2 * ln - 1; p = 64'(ln) & 64'hFFFF_FFFF; end
            18:    begin ln = val; ln = (ln >= 0) ? 2 * ln : -2 * ln - 1; p = ln; end
            1, 6, 16: begin wt = 1; is_var = 0; nfix = 8; end
            2, 7, 15: begin wt = 5; is_var = 0; nfix = 4; end
            default: exp_err = 1;
        endcase
        if (num == 0) exp_err = 1;
        if (!exp_err) begin
            push_varint(64'(num) * 8 + 64'(wt));
            if (is_var) push_varint(p);
            else for (int i = 0; i < nfix; i++) exp_q.push_back(8'(val >> (8 * i)));
        end
    endtask

    task automatic run_txn(input logic [28:0] num, input logic [4:0] ty, input logic [63:0] val,
                           input logic [63:0] dst, input int stall_first, input int stall_pct, input bit poke);
        int len, nb, k, cyc, stalls, srem, j;
        bit fin;
        logic [7:0]       ee;
        logic [7:0][63:0] ea;
        logic [7:0][7:0]  ed;
        model(num, ty, val);
        len = exp_err ? 0 : exp_q.size();
        nb = (len + 7) / 8;
        k = 0; cyc = 0; stalls = 0; srem = stall_first; fin = 0;
        @(negedge clk);
        f8.en = 1; f8.field_num = num; f8.field_type = ty; f8.value = val; f8.dst_addr = dst;
        while (!fin && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                f8.en = poke;
                if (poke) begin
                    f8.field_num = 29'd5; f8.field_type = 5'd3;
                    f8.value = {$urandom, $urandom}; f8.dst_addr = '0;
                end
                checks++;
                if (f8.busy !== 1'b1) begin errors++; $display("FAIL busy_enc: got %b want 1", f8.busy); end
            end else f8.en = 0;
            if (f8.dram_rdwr === 1'b1 || f8.dram_en !== 8'h00) begin
                if (k >= nb) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: cyc %0d dram_en %h beats_done %0d of %0d", cyc, f8.dram_en, k, nb);
                    f8.dram_ready = 1;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        j = k * 8 + i;
                        ee[i] = 0; ea[i] = '0; ed[i] = '0;
                        if (j < len) begin ee[i] = 1; ea[i] = dst + 64'(j); ed[i] = exp_q[j]; end
                    end
                    checks++;
                    if (f8.dram_en !== ee) begin errors++; $display("FAIL beat%0d_en: got %h want %h", k, f8.dram_en, ee); end
                    checks++;
                    if (f8.dram_data !== ed) begin errors++; $display("FAIL beat%0d_data: got %h want %h", k, f8.dram_data, ed); end
                    checks++;
                    if (f8.dram_addr !== ea) begin errors++; $display("FAIL beat%0d_addr: got %h want %h", k, f8.dram_addr, ea); end
                    checks++;
                    if (f8.dram_rdwr !== 1'b1) begin errors++; $display("FAIL beat%0d_rdwr: got %b want 1", k, f8.dram_rdwr); end
                    if (srem > 0) begin srem--; stalls++; f8.dram_ready = 0; end
                    else if ($urandom_range(0, 99) < stall_pct) begin stalls++; f8.dram_ready = 0; end
                    else begin f8.dram_ready = 1; k++; end
                end
            end else f8.dram_ready = 1'($urandom_range(0, 1));
            if (f8.done === 1'b1) begin
                fin = 1;
                checks++;
                if (cyc != 2 + nb + stalls) begin errors++; $display("FAIL done_cycle: got %0d want %0d", cyc, 2 + nb + stalls); end
                checks++;
                if (f8.error !== exp_err) begin errors++; $display("FAIL error_flag: got %b want %b", f8.error, exp_err); end
                checks++;
                if (f8.bytes_written !== 4'(len)) begin errors++; $display("FAIL bytes_written: got %0d want %0d", f8.bytes_written, len); end
                checks++;
                if (k != nb) begin errors++; $display("FAIL beats_accepted: got %0d want %0d", k, nb); end
            end
        end
        if (!fin) begin checks++; errors++; $display("FAIL done_timeout: no done within %0d cycles", cyc); end
        obs_bw = f8.bytes_written;
        f8.en = 0;
        f8.dram_ready = 1;
    endtask

    task automatic test_reset();
        checks++;
        if (f8.dram_en !== 8'h00 || f8.dram_addr !== '0 || f8.dram_data !== '0 || f8.dram_rdwr !== 1'b0 ||
            f8.busy !== 1'b0 || f8.done !== 1'b0 || f8.error !== 1'b0 || f8.bytes_written !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: en %h rdwr %b busy %b done %b err %b bw %0d want all 0",
                     f8.dram_en, f8.dram_rdwr, f8.busy, f8.done, f8.error, f8.bytes_written);
        end
        checks++;
        if (f1.dram_en !== 1'b0 || f1.busy !== 1'b0 || f1.done !== 1'b0) begin
            errors++; $display("FAIL reset_outputs_l1: en %b busy %b done %b want 0", f1.dram_en, f1.busy, f1.done);
        end
    endtask

    task automatic test_spec_vectors();
        run_txn(29'd1, 5'd5, 64'd150, 64'h100, 0, 0, 0);
        checks++; if (obs_bw !== 4'd3) begin errors++; $display("FAIL vec1_bw: got %0d want 3", obs_bw); end
        run_txn(29'd2, 5'd17, 64'hFFFF_FFFF, 64'h100, 0, 0, 0);
        checks++; if (obs_bw !== 4'd2) begin errors++; $display("FAIL vec2a_bw: got %0d want 2", obs_bw); end
        run_txn(29'd300, 5'd4, 64'd0, 64'h100, 0, 0, 0);
        checks++; if (obs_bw !== 4'd3) begin errors++; $display("FAIL vec2b_bw: got %0d want 3", obs_bw); end
        run_txn(29'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 0, 0, 1);
        checks++; if (obs_bw !== 4'd11) begin errors++; $display("FAIL vec3_bw: got %0d want 11", obs_bw); end
        run_txn(29'd3, 5'd7, 64'h1234_5678, 64'h100, 0, 0, 0);
        checks++; if (obs_bw !== 4'd5) begin errors++; $display("FAIL vec4_bw: got %0d want 5", obs_bw); end
    endtask

    task automatic test_backpressure();
        run_txn(29'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 3, 0, 0);
        run_txn(29'h1FFF_FFFF, 5'd1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFC, 1, 30, 0);
    endtask

    task automatic test_errors();
        run_txn(29'd4, 5'd9, 64'd77, 64'h300, 0, 0, 0);
        checks++; if (obs_bw !== 4'd0) begin errors++; $display("FAIL err_type_bw: got %0d want 0", obs_bw); end
        run_txn(29'd0, 5'd5, 64'd1, 64'h300, 0, 0, 1);
        checks++; if (obs_bw !== 4'd0) begin errors++; $display("FAIL err_num0_bw: got %0d want 0", obs_bw); end
    endtask

    task automatic test_lanes1();
        int cyc, k;
        bit fin;
        model(29'd3, 5'd7, 64'h1234_5678);
        k = 0; cyc = 0; fin = 0;
        @(negedge clk);
        f1.en = 1; f1.field_num = 29'd3; f1.field_type = 5'd7; f1.value = 64'h1234_5678; f1.dst_addr = 64'h200;
        while (!fin && cyc < 50) begin
            @(negedge clk);
            cyc++;
            f1.en = 0;
            if (f1.dram_en !== 1'b0) begin
                checks++;
                if (k >= exp_q.size() || f1.dram_addr !== 64'h200 + 64'(k) || f1.dram_data !== exp_q[k]) begin
                    errors++;
                    $display("FAIL l1_beat%0d: got en %b addr %h data %h", k, f1.dram_en, f1.dram_addr, f1.dram_data);
                end
                k++;
            end
            if (f1.done === 1'b1) begin
                fin = 1;
                checks++;
                if (cyc != 7) begin errors++; $display("FAIL l1_done_cycle: got %0d want 7", cyc); end
                checks++;
                if (f1.bytes_written !== 4'd5 || k != 5) begin
                    errors++; $display("FAIL l1_bytes: got bw %0d beats %0d want 5 5", f1.bytes_written, k);
                end
            end
        end
        if (!fin) begin checks++; errors++; $display("FAIL l1_timeout: no done within %0d cycles", cyc); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        f8.en = 1; f8.field_num = 29'd1; f8.field_type = 5'd3;
        f8.value = 64'hFFFF_FFFF_FFFF_FFFF; f8.dst_addr = 64'h100; f8.dram_ready = 1;
        @(negedge clk); f8.en = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (f8.dram_en !== 8'h07) begin errors++; $display("FAIL rst_mid_beat1: got %h want 07", f8.dram_en); end
        reset = 1;
        @(negedge clk);
        checks++;
        if (f8.dram_en !== 8'h00 || f8.dram_rdwr !== 1'b0 || f8.busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop: en %h rdwr %b busy %b want 0", f8.dram_en, f8.dram_rdwr, f8.busy);
        end
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (f8.done !== 1'b0 || f8.dram_en !== 8'h00) begin
                errors++; $display("FAIL rst_mid_quiet: cyc %0d done %b en %h want 0", c, f8.done, f8.dram_en);
            end
        end
    endtask

    task automatic test_random();
        logic [28:0] num;
        logic [63:0] val;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
                0:       num = 29'd0;
                1:       num = 29'($urandom_range(1, 15));
                2:       num = 29'h1FFF_FFFF;
                default: num = 29'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       val = 64'($urandom_range(0, 300));
                1:       val = ~64'($urandom_range(0, 300));
                2:       val = 64'd0;
                default: val = {$urandom, $urandom};
            endcase
            run_txn(num, 5'($urandom_range(0, 31)), val, {$urandom, $urandom}, 0, 25, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1;
        f8.en = 0; f8.field_num = '0; f8.field_type = '0; f8.value = '0; f8.dst_addr = '0; f8.dram_ready = 1;
        f1.en = 0; f1.field_num = '0; f1.field_type = '0; f1.value = '0; f1.dst_addr = '0; f1.dram_ready = 1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 0;
        @(negedge clk);
        test_reset();
        test_spec_vectors();
        test_errors();
        test_backpressure();
        test_lanes1();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
